// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD output controller: FSM states,
// panel timing totals, colour-bar table and default background colour.
package lcd_pkg;

  typedef enum logic [1:0] {
    WAIT_VS,
    PRIME,
    RUN
  } lcd_state_t;

  localparam logic [15:0] BG_DEFAULT = 16'h0000;

  // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lcd_pix_fifo.sv
// Single-clock pixel FIFO. The read register loads the popped word, or
// alt_data when no pop succeeds, so it doubles as the panel data register.
module lcd_pix_fifo #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter logic [DW-1:0] RST_DATA = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] alt_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok || flush);

  // A flush restarts at address 0 but keeps a push from the same cycle
  always_ff @(posedge clk) begin
    if (push_ok) mem[flush ? '0 : wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= RST_DATA;
    end else begin
      rd_data <= pop_ok ? mem[rd_ptr] : alt_data;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= push ? AW'(1) : '0;
        count  <= push ? (AW+1)'(1) : '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_out_ctrl.sv
// Buffers the scaler pixel stream and regenerates fixed LCD panel timing.
// Optional colour-bar test pattern (testPat port) under LCD_TEST_PATTERN_EN.
module lcd_out_ctrl
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int OUTPUT_RES_WIDTH = 11,
  parameter int FIFO_AW          = 10,
  parameter int PRIME_LEVEL      = 8,
  parameter int H_ACTIVE         = 480,
  parameter int H_FP             = 2,
  parameter int H_SYNC           = 41,
  parameter int H_BP             = 2,
  parameter int V_ACTIVE         = 272,
  parameter int V_FP             = 2,
  parameter int V_SYNC           = 10,
  parameter int V_BP             = 2,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = DATA_WIDTH'(BG_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     dIn,
  input  logic                      dInEn,
  input  logic                      sclVS,
  input  logic [OUTPUT_RES_WIDTH:0] outXRes,
  input  logic [OUTPUT_RES_WIDTH:0] outYRes,
  input  logic                      clrFlags,
`ifdef LCD_TEST_PATTERN_EN
  input  logic                      testPat,
`endif
  output logic [DATA_WIDTH-1:0]     lcdData,
  output logic                      lcdDE,
  output logic                      lcdHS,
  output logic                      lcdVS,
  output logic [FIFO_AW:0]          fifoNum,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW    = OUTPUT_RES_WIDTH + 1;
  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS_C  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE_C  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_MAX_C = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS_C  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE_C  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_MAX_C = CW'(V_TOT - 1);
  localparam logic [FIFO_AW:0] PRIME_C = (FIFO_AW+1)'(PRIME_LEVEL);

  lcd_state_t state, state_nxt;
  logic [CW-1:0] h_cnt, v_cnt;
  logic scl_vs_q, vs_edge, flush, run;
  logic act, img, hs_on, vs_on, h_end, v_end, frame_end;
  logic pop_req, fifo_full, fifo_empty, drop_evt, under_evt, under_lat, pat_on;
  logic [DATA_WIDTH-1:0] alt_data;

  assign run       = (state == RUN);
  assign vs_edge   = sclVS && !scl_vs_q;
  assign flush     = (state == WAIT_VS) && vs_edge;
  assign act       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign img       = act && (h_cnt < outXRes) && (v_cnt < outYRes);
  assign hs_on     = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
  assign vs_on     = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
  assign h_end     = (h_cnt == H_MAX_C);
  assign v_end     = (v_cnt == V_MAX_C);
  assign frame_end = h_end && v_end;
  assign pop_req   = run && img && !pat_on;
  assign under_evt = pop_req && fifo_empty;
  assign drop_evt  = dInEn && fifo_full && !pop_req && !flush;

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign pat_on   = testPat;
  assign bar_idx  = 3'((int'(h_cnt) * 8) / H_ACTIVE);
  assign alt_data = (pat_on && run && act) ? DATA_WIDTH'(BAR_COLORS[bar_idx]) : BG_COLOR;
`else
  assign pat_on   = 1'b0;
  assign alt_data = BG_COLOR;
`endif

  lcd_pix_fifo #(
    .DW       (DATA_WIDTH),
    .AW       (FIFO_AW),
    .RST_DATA (BG_COLOR)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (dInEn),
    .pop      (pop_req),
    .wr_data  (dIn),
    .alt_data (alt_data),
    .rd_data  (lcdData),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifoNum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (vs_edge) state_nxt = PRIME;
      PRIME:   if (fifoNum >= PRIME_C) state_nxt = RUN;
      RUN:     if (under_lat && frame_end) state_nxt = WAIT_VS;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // Underflow latch only lives for the current RUN frame; it forces a resync at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_VS;
      scl_vs_q  <= 1'b0;
      under_lat <= 1'b0;
    end else begin
      state    <= state_nxt;
      scl_vs_q <= sclVS;
      if (!run)          under_lat <= 1'b0;
      else if (under_evt) under_lat <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Flag set wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcdDE     <= 1'b0;
      lcdHS     <= 1'b1;
      lcdVS     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      lcdDE     <= act && run;
      lcdHS     <= run ? !hs_on : 1'b1;
      lcdVS     <= run ? !vs_on : 1'b1;
      overflow  <= drop_evt  ? 1'b1 : (clrFlags ? 1'b0 : overflow);
      underflow <= under_evt ? 1'b1 : (clrFlags ? 1'b0 : underflow);
    end
  end

endmodule

// File: doc/lcd_out_ctrl.md
Name: lcd_out_ctrl

Overview:
Sink for the scaler's output pixel stream (dOut/dOutEn/VS), running in the scaler output clock domain. Buffers pixels in an internal pixel FIFO and regenerates fixed LCD panel timing (active-low HSYNC/VSYNC, DE, RGB565 data). Places the scaled image of outXRes x outYRes at the top-left of the panel and fills the rest with a background colour. Resynchronises to the scaler frame start after an underflow.

Parameters:
DATA_WIDTH, 16, pixel width (RGB565)
OUTPUT_RES_WIDTH, 11, resolution port width is OUTPUT_RES_WIDTH+1
FIFO_AW, 10, pixel FIFO address width; depth = 2^FIFO_AW
PRIME_LEVEL, 8, FIFO fill that must be reached before the panel frame starts
H_ACTIVE/H_FP/H_SYNC/H_BP, 480/2/41/2, horizontal timing in clocks
V_ACTIVE/V_FP/V_SYNC/V_BP, 272/2/10/2, vertical timing in lines
BG_COLOR, 16'h0000, colour outside the image and on underflow

Ports:
clk  in  1  pixel clock (scaler clkb)
rst  in  1  reset, asynchronous, active-high
dIn  in  DATA_WIDTH  scaler output pixel
dInEn  in  1  pixel valid; one push per high cycle
sclVS  in  1  scaler frame sync; rising edge = new frame
outXRes  in  OUTPUT_RES_WIDTH+1  image width in pixels
outYRes  in  OUTPUT_RES_WIDTH+1  image height in lines
clrFlags  in  1  clears the sticky flags
lcdData  out  DATA_WIDTH  panel pixel
lcdDE  out  1  data enable
lcdHS  out  1  HSYNC, active-low
lcdVS  out  1  VSYNC, active-low
fifoNum  out  FIFO_AW+1  FIFO fill count
overflow  out  1  sticky: a push was dropped
underflow  out  1  sticky: a pop was attempted on an empty FIFO

Behaviour:
- Reset values: lcdData=BG_COLOR, lcdDE=0, lcdHS=1, lcdVS=1, fifoNum=0, both flags=0, state=WAIT_VS, hCnt=vCnt=0. Reset asserted mid-frame aborts immediately and flushes the FIFO.
- FIFO push: dInEn and not full.
  - dInEn while full with no pop in the same cycle: pixel dropped, overflow<=1.
  - Full with a simultaneous pop: push accepted, count unchanged.
  - Pointers wrap modulo 2^FIFO_AW; fifoNum ranges 0..2^FIFO_AW.
- sclVS rising edge: detected via a registered previous value; the edge cycle is the cycle where sclVS=1 and prev=0.
- State machine:
  - WAIT_VS -> PRIME on a sclVS rising edge. FIFO is flushed on the edge cycle; a push on that same cycle is kept.
  - PRIME -> RUN when fifoNum >= PRIME_LEVEL. Counters are held at 0.
  - RUN: counters free-run. hCnt wraps at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1; vCnt increments on hCnt wrap and wraps at V_TOTAL-1. Further sclVS edges are ignored.
  - RUN -> WAIT_VS when underflowLatched and the frame is complete (hCnt and vCnt both at their maximum). underflowLatched is set on the first failed pop of the frame.
- Decode, combinational on the counters:
  - act = hCnt<H_ACTIVE && vCnt<V_ACTIVE
  - img = act && hCnt<outXRes && vCnt<outYRes
  - pop = RUN && img
  - HS asserted when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on vCnt.
- Pop on an empty FIFO: no pointer change, underflow<=1, pixel = BG_COLOR.
- Outputs are registered, one cycle after their counter value:
  - lcdDE = act && RUN
  - lcdData = FIFO read data if pop succeeded, else BG_COLOR
  - lcdHS/lcdVS = inverted decodes when RUN, 1 otherwise.
- outXRes/outYRes above H_ACTIVE/V_ACTIVE are clipped by the act term. Excess scaler pixels accumulate and cause overflow.
- clrFlags clears both sticky flags. If a new event occurs in the same cycle, the flag is set (set wins).
- Counter width: OUTPUT_RES_WIDTH+1 bits; H_TOTAL and V_TOTAL must be < 2^(OUTPUT_RES_WIDTH+1).

Optional Feature:
LCD_TEST_PATTERN_EN:
- Defined: adds input testPat. When testPat=1, lcdData in the act region is eight vertical colour bars, bar index = hCnt*8/H_ACTIVE, values from a constant table. The FIFO is not popped and underflow does not update; timing is unchanged.
- Undefined: no testPat port; behaviour as above.

Decomposition:
- Package lcd_pkg holds: state enum (WAIT_VS, PRIME, RUN), H_TOTAL/V_TOTAL derivation functions, colour-bar table, BG default.
- One sub-module, lcd_pix_fifo: single-clock FIFO with push/pop/full/empty/count and registered read data.

Test Plan:
1. Small timing (H_ACTIVE=8, H_FP=H_SYNC=H_BP=1, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1), outX/YRes=8/4, PRIME_LEVEL=4; sclVS edge, 32 pixels 0..31 at one per clock -> lcdDE high 8 of every 11 clocks on 4 lines; lcdData 0..31 in order; lcdHS low 1 clock per line; lcdVS low for 1 line (11 clocks).
2. outXRes=5, outYRes=2, same panel -> per line data 5 pixels then 3 x BG_COLOR; lines 2-3 all BG_COLOR; no underflow.
3. Only 10 pixels supplied in test 1 -> pixel 11 slot shows BG_COLOR and underflow=1; after the frame, state returns to WAIT_VS with lcdDE=0; next sclVS edge restarts cleanly.
4. FIFO_AW=3, 12 pixels pushed in PRIME with PRIME_LEVEL=9 -> fifoNum saturates at 8, overflow=1; clrFlags pulse -> overflow=0.
5. Assert rst mid-line during RUN -> all outputs at reset values within the same cycle (async), fifoNum=0.
6. With LCD_TEST_PATTERN_EN, testPat=1 -> bar values per hCnt, fifoNum unchanged, underflow stays 0.
